// File: rtl/fp_mul_round_pack_if.sv
// Handshake and payload bundle between the multiplier array, the round/pack stage
// and its consumer. master drives operands and out_ready; slave is the stage itself.
interface fp_mul_round_pack_if;
  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic signed [9:0]  in_exp;
  logic [47:0]        in_prod;
  logic [1:0]         in_cls;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        s;
  logic               overflow;
  logic               underflow;
  logic               inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_prod, in_cls, out_ready,
    input  in_ready, out_valid, s, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_prod, in_cls, out_ready,
    output in_ready, out_valid, s, overflow, underflow, inexact
  );
endinterface

// File: rtl/fp_mul_round_pack.sv
// Two-stage normalize / round-to-nearest-even / pack for binary32 multiply.
// Define FPMUL_DENORM_EN to build gradual underflow; otherwise tiny results flush to zero.
module fp_mul_round_pack (
  input  logic                      clk,
  input  logic                      rst,
  fp_mul_round_pack_if.slave        bus
);
  localparam int unsigned EW = 10;
  localparam int unsigned MW = 23;
  localparam logic [1:0]  CLS_NORM = 2'b00;
  localparam logic [1:0]  CLS_ZERO = 2'b01;
  localparam logic [1:0]  CLS_INF  = 2'b10;

  logic                 v1, v2, ld1, ld2;
  logic                 sign1, g1, st1, tiny1;
  logic signed [EW-1:0] e1;
  logic [MW-1:0]        m1;
  logic [1:0]           cls1;

  logic [31:0]          s_q;
  logic                 ovf_q, unf_q, inx_q;

  // Stage 2 accepts when empty or draining; stage 1 when empty or moving into stage 2
  assign ld2          = !v2 || bus.out_ready;
  assign ld1          = !v1 || ld2;
  assign bus.in_ready = ld1;
  assign bus.out_valid = v2;
  assign bus.s         = s_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.inexact   = inx_q;

  logic signed [EW-1:0] e_n, e_c;
  logic [MW-1:0]        m_n, m_c;
  logic                 g_n, g_c, st_n, st_c, tiny_c;
`ifdef FPMUL_DENORM_EN
  logic [EW-1:0]        sh;
  logic [24:0]          val, mask;
  logic [23:0]          shd;
`endif

  // Stage 1: align product so the leading one is implicit
  always_comb begin
    if (bus.in_prod[47]) begin
      e_n  = bus.in_exp + EW'(1);
      m_n  = bus.in_prod[46:24];
      g_n  = bus.in_prod[23];
      st_n = |bus.in_prod[22:0];
    end else begin
      e_n  = bus.in_exp;
      m_n  = bus.in_prod[45:23];
      g_n  = bus.in_prod[22];
      st_n = |bus.in_prod[21:0];
    end
    tiny_c = e_n[EW-1] || (e_n == '0);
    e_c  = e_n;
    m_c  = m_n;
    g_c  = g_n;
    st_c = st_n;
`ifdef FPMUL_DENORM_EN
    // Denormalize: shift hidden one into the fraction, sticky collects everything lost
    sh   = EW'(1) - e_n;
    val  = {1'b1, m_n, g_n};
    shd  = '0;
    mask = '0;
    if (tiny_c) begin
      e_c = '0;
      if (sh >= EW'(25)) begin
        m_c  = '0;
        g_c  = 1'b0;
        st_c = 1'b1;
      end else begin
        shd  = 24'(val >> sh[4:0]);
        mask = (25'(1) << sh[4:0]) - 25'(1);
        m_c  = shd[23:1];
        g_c  = shd[0];
        st_c = st_n | (|(val & mask));
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      e1    <= '0;
      m1    <= '0;
      g1    <= 1'b0;
      st1   <= 1'b0;
      tiny1 <= 1'b0;
      cls1  <= CLS_NORM;
    end else if (ld1) begin
      v1    <= bus.in_valid;
      sign1 <= bus.in_sign;
      e1    <= e_c;
      m1    <= m_c;
      g1    <= g_c;
      st1   <= st_c;
      tiny1 <= tiny_c;
      cls1  <= bus.in_cls;
    end
  end

  logic                 up;
  logic [MW:0]          sum;
  logic signed [EW-1:0] e_r;
  logic [31:0]          s_c;
  logic                 ovf_c, unf_c, inx_c;

  // Stage 2: round to nearest even, detect overflow, pack or bypass specials
  always_comb begin
    up    = g1 & (st1 | m1[0]);
    sum   = {1'b0, m1} + {{MW{1'b0}}, up};
    e_r   = sum[MW] ? (e1 + EW'(1)) : e1;
    s_c   = '0;
    ovf_c = 1'b0;
    unf_c = 1'b0;
    inx_c = 1'b0;
    case (cls1)
      CLS_ZERO: s_c = {sign1, 31'b0};
      CLS_INF:  s_c = {sign1, 8'hFF, 23'b0};
      CLS_NORM: begin
        inx_c = g1 | st1;
        if (!e_r[EW-1] && (e_r[8:0] >= 9'd255)) begin
          s_c   = {sign1, 8'hFF, 23'b0};
          ovf_c = 1'b1;
          inx_c = 1'b1;
        end else begin
          s_c = {sign1, e_r[7:0], sum[MW-1:0]};
        end
`ifdef FPMUL_DENORM_EN
        unf_c = tiny1 & inx_c;
`else
        if (tiny1) begin
          s_c   = {sign1, 31'b0};
          ovf_c = 1'b0;
          unf_c = 1'b1;
          inx_c = 1'b1;
        end
`endif
      end
      default:  s_c = 32'h7FC0_0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      s_q   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inx_q <= 1'b0;
    end else if (ld2) begin
      v2    <= v1;
      s_q   <= s_c;
      ovf_q <= ovf_c;
      unf_q <= unf_c;
      inx_q <= inx_c;
    end
  end
endmodule
